// File: rtl/buf_fifo_if.sv
// Producer/consumer handshake bundle for buf_fifo; the FIFO takes the slave side.
interface buf_fifo_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             afull;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty, afull
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty, afull
  );
endinterface

// File: rtl/buf_fifo.sv
// Registered elastic FIFO with valid/ready on both sides, occupancy flags and sync flush.
// All flags decode from the registered count; no ready or data bypass paths.
module buf_fifo #(
  parameter int WIDTH    = 3,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  buf_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "buf_fifo: DEPTH must be a power of 2 in 2..64");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $fatal(1, "buf_fifo: AF_LEVEL must be in 1..DEPTH");
  end
  if ((WIDTH < 1) || (WIDTH > 128)) begin : g_bad_width
    $fatal(1, "buf_fifo: WIDTH must be in 1..128");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, empty, push, pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = bus.in_valid  && !full;
  assign pop   = bus.out_ready && !empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      // flush wins over any handshake in the same cycle
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // storage is deliberately unreset; head data is meaningless while empty
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wp_q] <= bus.in_data;
  end

  assign bus.out_data  = mem_q[rp_q];
  assign bus.out_valid = !empty;
  assign bus.in_ready  = !full;
  assign bus.count     = cnt_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.afull     = (cnt_q >= AF_CNT);
endmodule
